// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the execute-stage branch resolution logic.
package branch_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches/jumps against the fetch prediction: redirect/flush, predictor training, perf counters.
//   state   | meaning
//   IDLE    | normal operation, EX may resolve a branch
//   RECOVER | EX holds the bubble flushed by the last redirect
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             CondTakenE,
  input  logic             Predict_branchE,
  input  logic [XLEN-1:0]  PredTargetE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  BrTargetE,
  input  logic             StallE,
  input  logic             cnt_clr,
  output logic             RedirectE,
  output logic [XLEN-1:0]  RedirectPCE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             Eval_branch,
  output logic             PCSrcE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic [XLEN-1:0]  UpdPC,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic             proto_err
);

  brs_state_e      state_q, state_d;
  logic            done_q, done_d;
  logic            eval_q, eval_d;
  logic            pcsrc_q, pcsrc_d;
  logic            proto_err_q, proto_err_d;
  logic [XLEN-1:0] pctarget_q, pctarget_d;
  logic [XLEN-1:0] updpc_q, updpc_d;

  logic ctl, taken, mispredict, fire, redirect;

  always_comb begin
    ctl        = BranchE | JumpE;
    taken      = JumpE | (BranchE & CondTakenE);
    mispredict = ctl & ((Predict_branchE != taken) |
                        (taken & Predict_branchE & (PredTargetE != BrTargetE)));
    // Gated by rst so the redirect path is quiet while the block is held in reset.
    fire       = rst & ctl & ~done_q & (state_q == IDLE);
    redirect   = fire & mispredict;

    state_d = (state_q == IDLE && redirect) ? RECOVER : IDLE;

    // A stalled instruction is re-presented; done_q keeps it from resolving twice.
    done_d = StallE ? (done_q | fire) : 1'b0;

    eval_d     = fire;
    pcsrc_d    = fire ? taken     : pcsrc_q;
    pctarget_d = fire ? BrTargetE : pctarget_q;
    updpc_d    = fire ? PCE       : updpc_q;

    // The held copy of the redirecting branch is not a protocol violation.
    proto_err_d = proto_err_q | ((state_q == RECOVER) & ctl & ~done_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      eval_q      <= 1'b0;
      pcsrc_q     <= 1'b0;
      pctarget_q  <= '0;
      updpc_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      eval_q      <= eval_d;
      pcsrc_q     <= pcsrc_d;
      pctarget_q  <= pctarget_d;
      updpc_q     <= updpc_d;
      proto_err_q <= proto_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fire),
    .clr (cnt_clr),
    .q   (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .clr (cnt_clr),
    .q   (mp_cnt)
  );

  assign RedirectE   = redirect;
  assign FlushD      = redirect;
  assign FlushE      = redirect;
  assign RedirectPCE = redirect ? (taken ? BrTargetE : PCPlus4E) : '0;
  assign Eval_branch = eval_q;
  assign PCSrcE      = pcsrc_q;
  assign PCTargetE   = pctarget_q;
  assign UpdPC       = updpc_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: training updates queued at issue, checked when Eval_branch fires.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk, rst;
  logic             BranchE, JumpE, CondTakenE, Predict_branchE, StallE, cnt_clr;
  logic [XLEN-1:0]  PredTargetE, PCE, PCPlus4E, BrTargetE;
  logic             RedirectE, FlushD, FlushE, Eval_branch, PCSrcE, proto_err;
  logic [XLEN-1:0]  RedirectPCE, PCTargetE, UpdPC;
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .BranchE(BranchE), .JumpE(JumpE), .CondTakenE(CondTakenE),
    .Predict_branchE(Predict_branchE), .PredTargetE(PredTargetE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .BrTargetE(BrTargetE), .StallE(StallE), .cnt_clr(cnt_clr), .RedirectE(RedirectE),
    .RedirectPCE(RedirectPCE), .FlushD(FlushD), .FlushE(FlushE), .Eval_branch(Eval_branch),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .UpdPC(UpdPC), .br_cnt(br_cnt), .mp_cnt(mp_cnt),
    .proto_err(proto_err)
  );

  typedef struct {
    int              cyc;
    logic            taken;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  logic             mon_en = 1'b0;
  logic [CNT_W-1:0] exp_br = '0;
  logic [CNT_W-1:0] exp_mp = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Training monitor: every cycle Eval_branch must match exactly what the scoreboard expects.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (Eval_branch !== 1'b1) begin
          errors++; $display("FAIL eval_missing: cyc %0d got %b want 1", cyc, Eval_branch);
        end
        checks++;
        if (PCSrcE !== e.taken) begin
          errors++; $display("FAIL pcsrc: cyc %0d got %b want %b", cyc, PCSrcE, e.taken);
        end
        checks++;
        if (PCTargetE !== e.tgt) begin
          errors++; $display("FAIL pctarget: cyc %0d got %h want %h", cyc, PCTargetE, e.tgt);
        end
        checks++;
        if (UpdPC !== e.pc) begin
          errors++; $display("FAIL updpc: cyc %0d got %h want %h", cyc, UpdPC, e.pc);
        end
      end else begin
        checks++;
        if (Eval_branch !== 1'b0) begin
          errors++; $display("FAIL eval_spurious: cyc %0d got %b want 0", cyc, Eval_branch);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic br, input logic jmp, input logic cond, input logic pred,
                        input logic [XLEN-1:0] predt, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] brt, input logic stall);
    BranchE = br; JumpE = jmp; CondTakenE = cond; Predict_branchE = pred;
    PredTargetE = predt; PCE = pc; PCPlus4E = pc + 32'd4; BrTargetE = brt; StallE = stall;
  endtask

  task automatic clr_in;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic push(input logic taken, input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] pc);
    exp_t x;
    x.cyc = cyc + 1; x.taken = taken; x.tgt = tgt; x.pc = pc;
    sb.push_back(x);
  endtask

  task automatic bump_br; if (exp_br != '1) exp_br = exp_br + 4'd1; endtask
  task automatic bump_mp; if (exp_mp != '1) exp_mp = exp_mp + 4'd1; endtask

  task automatic test_reset;
    rst = 1'b0; cnt_clr = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h20, 32'h10, 1'b0);
    #12;
    checks++;
    if ({RedirectE, FlushD, FlushE, Eval_branch, PCSrcE, proto_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {RedirectE, FlushD, FlushE, Eval_branch, PCSrcE, proto_err});
    end
    checks++;
    if ({RedirectPCE, PCTargetE, UpdPC} !== 96'h0) begin
      errors++; $display("FAIL reset_buses: got %h %h %h want 0", RedirectPCE, PCTargetE, UpdPC);
    end
    checks++;
    if ({br_cnt, mp_cnt} !== 8'h0) begin
      errors++; $display("FAIL reset_cnt: got %h %h want 0 0", br_cnt, mp_cnt);
    end
    clr_in;
    @(negedge clk); rst = 1'b1; mon_en = 1'b1;
    tick;
  endtask

  task automatic test_correct_taken;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h80, 32'h100, 1'b0);
    push(1'b1, 32'h100, 32'h80); bump_br;
    @(negedge clk);
    checks++;
    if ({RedirectE, FlushD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL t1_no_redirect: got %b want 000", {RedirectE, FlushD, FlushE});
    end
    tick; clr_in;
    @(negedge clk);
    checks++;
    if (br_cnt !== exp_br || mp_cnt !== exp_mp) begin
      errors++; $display("FAIL t1_cnt: got %0d/%0d want %0d/%0d", br_cnt, mp_cnt, exp_br, exp_mp);
    end
    tick;
  endtask

  task automatic test_not_taken_mispredict;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h44, 32'h300, 1'b0);
    push(1'b0, 32'h300, 32'h44); bump_br; bump_mp;
    @(negedge clk);
    checks++;
    if ({RedirectE, FlushD, FlushE} !== 3'b111) begin
      errors++; $display("FAIL t2_redirect: got %b want 111", {RedirectE, FlushD, FlushE});
    end
    checks++;
    if (RedirectPCE !== 32'h48) begin
      errors++; $display("FAIL t2_redirect_pc: got %h want 00000048", RedirectPCE);
    end
    tick; clr_in;
    @(negedge clk);
    checks++;
    if (dut.state_q !== RECOVER) begin
      errors++; $display("FAIL t2_state_recover: got %0d want %0d", dut.state_q, RECOVER);
    end
    checks++;
    if (mp_cnt !== exp_mp) begin
      errors++; $display("FAIL t2_mp_cnt: got %0d want %0d", mp_cnt, exp_mp);
    end
    tick;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL t2_state_idle: got %0d want %0d", dut.state_q, IDLE);
    end
    tick;
  endtask

  task automatic test_jump_target;
    // BranchE with a false condition alongside JumpE: the jump still counts as taken.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1F0, 32'h204, 1'b0);
    push(1'b1, 32'h204, 32'h1F0); bump_br; bump_mp;
    @(negedge clk);
    checks++;
    if (RedirectE !== 1'b1 || RedirectPCE !== 32'h204) begin
      errors++; $display("FAIL t3_jump_redirect: got %b %h want 1 00000204", RedirectE, RedirectPCE);
    end
    tick; clr_in;
    @(negedge clk);
    checks++;
    if (mp_cnt !== exp_mp || br_cnt !== exp_br) begin
      errors++; $display("FAIL t3_cnt: got %0d/%0d want %0d/%0d", br_cnt, mp_cnt, exp_br, exp_mp);
    end
    tick;
  endtask

  task automatic test_stall;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h340, 1'b1);
    push(1'b1, 32'h340, 32'h300); bump_br; bump_mp;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) StallE = 1'b0;
      @(negedge clk);
      checks++;
      if (RedirectE !== (i == 0)) begin
        errors++; $display("FAIL t4_stall_redirect[%0d]: got %b want %b", i, RedirectE, (i == 0));
      end
      tick;
    end
    clr_in;
    @(negedge clk);
    checks++;
    if (br_cnt !== exp_br || mp_cnt !== exp_mp) begin
      errors++; $display("FAIL t4_cnt: got %0d/%0d want %0d/%0d", br_cnt, mp_cnt, exp_br, exp_mp);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL t4_proto_err: got %b want 0", proto_err);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic            t_br[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic            t_jmp[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic            t_cond[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic            t_pred[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [XLEN-1:0] t_pdt[4]  = '{32'h500, 32'h0, 32'h700, 32'h0};
    logic [XLEN-1:0] t_brt[4]  = '{32'h500, 32'h600, 32'h700, 32'h800};
    logic            t_tkn[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic            t_rdr[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [XLEN-1:0] t_rpc[4]  = '{32'h0, 32'h0, 32'h0, 32'h800};
    for (int k = 0; k < 4; k++) begin
      set_in(t_br[k], t_jmp[k], t_cond[k], t_pred[k], t_pdt[k], 32'h400 + 32'(4 * k), t_brt[k], 1'b0);
      push(t_tkn[k], t_brt[k], 32'h400 + 32'(4 * k)); bump_br;
      if (t_rdr[k]) bump_mp;
      @(negedge clk);
      checks++;
      if (RedirectE !== t_rdr[k] || RedirectPCE !== t_rpc[k]) begin
        errors++; $display("FAIL b2b_redirect[%0d]: got %b %h want %b %h",
                           k, RedirectE, RedirectPCE, t_rdr[k], t_rpc[k]);
      end
      tick;
    end
    clr_in;
    @(negedge clk);
    checks++;
    if (br_cnt !== exp_br || mp_cnt !== exp_mp) begin
      errors++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", br_cnt, mp_cnt, exp_br, exp_mp);
    end
    tick;
  endtask

  task automatic test_proto_err_and_reset;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h990, 32'h900, 32'h990, 1'b0);
    push(1'b0, 32'h990, 32'h900); bump_br; bump_mp;
    @(negedge clk);
    checks++;
    if (RedirectE !== 1'b1 || RedirectPCE !== 32'h904) begin
      errors++; $display("FAIL t5_redirect: got %b %h want 1 00000904", RedirectE, RedirectPCE);
    end
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hA00, 32'hA40, 1'b0);
    @(negedge clk);
    checks++;
    if (RedirectE !== 1'b0) begin
      errors++; $display("FAIL t5_recover_redirect: got %b want 0", RedirectE);
    end
    tick; clr_in;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL t5_proto_err: got %b want 1", proto_err);
    end
    checks++;
    if (br_cnt !== exp_br || mp_cnt !== exp_mp) begin
      errors++; $display("FAIL t5_cnt: got %0d/%0d want %0d/%0d", br_cnt, mp_cnt, exp_br, exp_mp);
    end
    tick;
    // Enter RECOVER again, then pull reset in the middle of it with a mispredict still presented.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hB00, 32'hB80, 1'b0);
    push(1'b1, 32'hB80, 32'hB00); bump_br; bump_mp;
    @(negedge clk);
    tick;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    exp_br = '0; exp_mp = '0;
    checks++;
    if ({RedirectE, FlushD, FlushE, Eval_branch, PCSrcE, proto_err} !== 6'b0) begin
      errors++; $display("FAIL t5_rst_flags: got %b want 000000",
                         {RedirectE, FlushD, FlushE, Eval_branch, PCSrcE, proto_err});
    end
    checks++;
    if ({RedirectPCE, PCTargetE, UpdPC} !== 96'h0) begin
      errors++; $display("FAIL t5_rst_buses: got %h %h %h want 0", RedirectPCE, PCTargetE, UpdPC);
    end
    checks++;
    if ({br_cnt, mp_cnt} !== 8'h0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL t5_rst_state: got %h %h %0d want 0 0 0", br_cnt, mp_cnt, dut.state_q);
    end
    clr_in;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    tick;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'hD00 + 32'(4 * i), 32'hC00 + 32'(4 * i),
             32'hD00 + 32'(4 * i), 1'b0);
      push(1'b1, 32'hD00 + 32'(4 * i), 32'hC00 + 32'(4 * i)); bump_br;
      tick;
    end
    clr_in;
    @(negedge clk);
    checks++;
    if (br_cnt !== 4'd15 || exp_br !== 4'd15) begin
      errors++; $display("FAIL t6_saturate: got %0d want 15", br_cnt);
    end
    checks++;
    if (mp_cnt !== 4'd0) begin
      errors++; $display("FAIL t6_mp_cnt: got %0d want 0", mp_cnt);
    end
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'hE00, 32'hE80, 32'hE00, 1'b0);
    cnt_clr = 1'b1;
    push(1'b1, 32'hE00, 32'hE80); exp_br = '0;
    tick;
    cnt_clr = 1'b0; clr_in;
    @(negedge clk);
    checks++;
    if (br_cnt !== 4'd0) begin
      errors++; $display("FAIL t6_clr_wins: got %0d want 0", br_cnt);
    end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_correct_taken;
    test_not_taken_mispredict;
    test_jump_target;
    test_stall;
    test_back_to_back;
    test_proto_err_and_reset;
    test_saturate;
    tick; tick;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
